// File: rtl/mux2to1_rr_arbiter_if.sv
// Bus bundle for mux2to1_rr_arbiter: requester handshakes, data and the arbitrated output stream.
// The gnt_cnt0/gnt_cnt1 statistics signals exist only when ARB_STATS_EN is defined.
interface mux2to1_rr_arbiter_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
);

  logic          req0;
  logic          req1;
  logic [DW-1:0] in0;
  logic [DW-1:0] in1;
  logic          gnt0;
  logic          gnt1;
  logic          sel;
  logic [DW-1:0] out;
  logic          out_vld;
  logic          busy;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;
`endif

  if (DW < 1 || CNT_W < 1) begin : g_param_err
    $error("mux2to1_rr_arbiter_if: DW and CNT_W must be >= 1");
  end

  // Arbiter side.
  modport slave (
    input  req0, req1, in0, in1,
`ifdef ARB_STATS_EN
    output gnt_cnt0, gnt_cnt1,
`endif
    output gnt0, gnt1, sel, out, out_vld, busy
  );

  // Requester / downstream side.
  modport master (
    output req0, req1, in0, in1,
`ifdef ARB_STATS_EN
    input  gnt_cnt0, gnt_cnt1,
`endif
    input  gnt0, gnt1, sel, out, out_vld, busy
  );

endinterface

// File: rtl/mux2to1_rr_arbiter.sv
// Round-robin arbitrated, registered 2:1 data mux with a bounded hold time under contention.
// Define ARB_STATS_EN to add per-port grant counters (gnt_cnt0/gnt_cnt1).
module mux2to1_rr_arbiter #(
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  mux2to1_rr_arbiter_if.slave bus
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_e;

  if (MAX_HOLD < 1 || CNT_W < 1) begin : g_param_err
    $error("mux2to1_rr_arbiter: MAX_HOLD and CNT_W must be >= 1");
  end

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              last_q, last_d;
  logic [DW-1:0]     out_q, out_d;
  logic              out_vld_q, out_vld_d;

  logic gnt0, gnt1, hold_at_max;

  assign gnt0        = (state_q == OWN0);
  assign gnt1        = (state_q == OWN1);
  assign hold_at_max = (hold_cnt_q == HOLD_LAST);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; that is what keeps the combinational block from inferring a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_q ? OWN0 : OWN1;
        else if (bus.req0)        state_d = OWN0;
        else if (bus.req1)        state_d = OWN1;
      end
      OWN0: begin
        if (!bus.req0)                    state_d = bus.req1 ? OWN1 : IDLE;
        else if (bus.req1 && hold_at_max) state_d = OWN1;
      end
      OWN1: begin
        if (!bus.req1)                    state_d = bus.req0 ? OWN0 : IDLE;
        else if (bus.req0 && hold_at_max) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q remembers the most recent owner so a tie from IDLE goes to the other port.
  always_comb begin
    last_d = last_q;
    if (state_q == OWN0 && state_d != OWN0)      last_d = 1'b0;
    else if (state_q == OWN1 && state_d != OWN1) last_d = 1'b1;
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q || state_d == IDLE) hold_cnt_d = '0;
    else if (!hold_at_max)                     hold_cnt_d = hold_cnt_q + HOLD_W'(1);
  end

  always_comb begin
    out_d     = gnt1 ? bus.in1 : bus.in0;
    out_vld_d = (gnt0 & bus.req0) | (gnt1 & bus.req1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      last_q     <= 1'b1;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.sel     = gnt1;
  assign bus.busy    = gnt0 | gnt1;
  assign bus.out     = out_q;
  assign bus.out_vld = out_vld_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt1_q;

  // Counts entries into ownership, not owned cycles; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      if (state_d == OWN0 && state_q != OWN0) gnt_cnt0_q <= gnt_cnt0_q + CNT_W'(1);
      if (state_d == OWN1 && state_q != OWN1) gnt_cnt1_q <= gnt_cnt1_q + CNT_W'(1);
    end
  end

  assign bus.gnt_cnt0 = gnt_cnt0_q;
  assign bus.gnt_cnt1 = gnt_cnt1_q;
`endif

  a_gnt_exclusive: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1))
    else $error("mux2to1_rr_arbiter: gnt0 and gnt1 both high");

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// Directed bench for mux2to1_rr_arbiter: a MAX_HOLD=4 instance for the main scenarios and a
// MAX_HOLD=1 instance for strict alternation (and grant counts when ARB_STATS_EN is defined).
module tb_mux2to1_rr_arbiter;

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mux2to1_rr_arbiter_if #(.DW(DW), .CNT_W(CNT_W)) bus4 ();
  mux2to1_rr_arbiter_if #(.DW(DW), .CNT_W(CNT_W)) bus1 ();

  mux2to1_rr_arbiter #(.DW(DW), .MAX_HOLD(4), .CNT_W(CNT_W)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  mux2to1_rr_arbiter #(.DW(DW), .MAX_HOLD(1), .CNT_W(CNT_W)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       exp_g1;
    logic [7:0] exp_out;

    rst       = 1'b1;
    bus4.req0 = 1'b0; bus4.req1 = 1'b0; bus4.in0 = '0; bus4.in1 = '0;
    bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.in0 = '0; bus1.in1 = '0;

    // 1: reset state, then a single requester on port 0.
    tick(); tick();
    check("rst_gnt0",    bus4.gnt0,    0);
    check("rst_gnt1",    bus4.gnt1,    0);
    check("rst_sel",     bus4.sel,     0);
    check("rst_busy",    bus4.busy,    0);
    check("rst_out_vld", bus4.out_vld, 0);
    check("rst_out",     bus4.out,     0);

    rst = 1'b0; bus4.req0 = 1'b1; bus4.in0 = 8'hA5;
    tick();
    check("t1_gnt0",        bus4.gnt0,    1);
    check("t1_busy",        bus4.busy,    1);
    check("t1_out_vld_lat", bus4.out_vld, 0);
    tick();
    check("t1_out",     bus4.out,     8'hA5);
    check("t1_out_vld", bus4.out_vld, 1);

    bus4.req0 = 1'b0;
    tick();
    check("t1_release_gnt0",    bus4.gnt0,    0);
    check("t1_release_out_vld", bus4.out_vld, 0);

    // 2: dual request straight out of reset; port 0 first, MAX_HOLD=4 runs of each.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus4.req0 = 1'b1; bus4.req1 = 1'b1; bus4.in0 = 8'h11; bus4.in1 = 8'h22;
    bus1.req0 = 1'b1; bus1.req1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_g1 = (((k - 1) / 4) % 2) == 1;
      check($sformatf("t2_gnt0[%0d]", k), bus4.gnt0, !exp_g1);
      check($sformatf("t2_gnt1[%0d]", k), bus4.gnt1, exp_g1);
      check($sformatf("t2_sel[%0d]", k),  bus4.sel,  exp_g1);
      if (k >= 2) begin
        exp_out = ((((k - 2) / 4) % 2) == 1) ? 8'h22 : 8'h11;
        check($sformatf("t2_out_vld[%0d]", k), bus4.out_vld, 1);
        check($sformatf("t2_out[%0d]", k),     bus4.out,     exp_out);
      end
      check($sformatf("t2_alt_gnt1[%0d]", k), bus1.gnt1, ((k - 1) % 2) == 1);
`ifdef ARB_STATS_EN
      if (k == 10) begin
        check("t6_gnt_cnt0", bus1.gnt_cnt0, 5);
        check("t6_gnt_cnt1", bus1.gnt_cnt1, 5);
      end
`endif
    end
    bus1.req0 = 1'b0; bus1.req1 = 1'b0;

    // 3: port 1 takes over by preemption, then drops req1 while port 0 still asks.
    tick();
    check("t3_gnt1",    bus4.gnt1,    1);
    check("t3_out_vld", bus4.out_vld, 1);
    check("t3_out",     bus4.out,     8'h11);
    bus4.req1 = 1'b0;
    tick();
    check("t3_handover_gnt0", bus4.gnt0,    1);
    check("t3_dropped_vld",   bus4.out_vld, 0);
    tick();
    check("t3_resume_vld", bus4.out_vld, 1);
    check("t3_resume_out", bus4.out,     8'h11);

    // 4: lone requester on port 1 keeps the mux indefinitely.
    bus4.req0 = 1'b0; bus4.req1 = 1'b1; bus4.in1 = 8'h3C;
    for (int j = 1; j <= 20; j++) begin
      tick();
      check($sformatf("t4_gnt1[%0d]", j), bus4.gnt1, 1);
      check($sformatf("t4_gnt0[%0d]", j), bus4.gnt0, 0);
      if (j >= 2) begin
        check($sformatf("t4_out_vld[%0d]", j), bus4.out_vld, 1);
        check($sformatf("t4_out[%0d]", j),     bus4.out,     8'h3C);
      end
    end

    // 5: reset mid-transfer, then re-arbitration with port 0 favoured.
    bus4.req0 = 1'b1; rst = 1'b1;
    tick();
    check("t5_rst_gnt0",    bus4.gnt0,    0);
    check("t5_rst_gnt1",    bus4.gnt1,    0);
    check("t5_rst_busy",    bus4.busy,    0);
    check("t5_rst_out_vld", bus4.out_vld, 0);
    check("t5_rst_out",     bus4.out,     0);
    rst = 1'b0;
    tick();
    check("t5_regrant_gnt0", bus4.gnt0, 1);

    // Tie after port 0 was last owner goes to port 1.
    bus4.req0 = 1'b0; bus4.req1 = 1'b0;
    tick();
    check("t5_idle_busy", bus4.busy, 0);
    bus4.req0 = 1'b1; bus4.req1 = 1'b1;
    tick();
    check("t5_tie_gnt1", bus4.gnt1, 1);
    check("t5_tie_gnt0", bus4.gnt0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
